// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its branch target buffer.
// The counter encoding is a 2-bit saturating predictor; the MSB is the predicted direction.
package if_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam logic [31:0] NOP             = 32'h0000_0013;
   localparam int          BTB_ENTRIES_DEF = 16;

   // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
   function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/if_fetch_stage_btb.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters.
// Lookup is combinational; updates land at the edge and are seen by lookups the next cycle.
module btb_bht
   import if_pkg::*;
#(
   parameter  int BTB_ENTRIES = BTB_ENTRIES_DEF,
   localparam int IDX_W       = $clog2(BTB_ENTRIES),
   localparam int TAG_W       = 30 - IDX_W
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_lkp_pc,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   input  logic        i_upd_en,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target
);

   logic [BTB_ENTRIES-1:0] valid_q;
   ctr_e                   ctr_q    [BTB_ENTRIES];
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [31:0]            target_q [BTB_ENTRIES];

   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] l_tag;
   logic [TAG_W-1:0] u_tag;
   logic [1:0]       l_ctr;
   logic             u_hit;

   assign l_idx = IDX_W'(btb_index(i_lkp_pc, IDX_W));
   assign l_tag = TAG_W'(btb_tag(i_lkp_pc, IDX_W));
   assign u_idx = IDX_W'(btb_index(i_upd_pc, IDX_W));
   assign u_tag = TAG_W'(btb_tag(i_upd_pc, IDX_W));

   // valid gates first so uninitialised tag/target never leak into the prediction.
   assign l_ctr         = ctr_q[l_idx];
   assign o_pred_taken  = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && l_ctr[1];
   assign o_pred_target = target_q[l_idx];
   assign u_hit         = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            ctr_q[i] <= WNT;
         end
      end else if (i_upd_en) begin
         if (u_hit) begin
            if (i_upd_taken) begin
               ctr_q[u_idx] <= (ctr_q[u_idx] == ST) ? ST : ctr_e'(ctr_q[u_idx] + 2'd1);
            end else begin
               ctr_q[u_idx] <= (ctr_q[u_idx] == SNT) ? SNT : ctr_e'(ctr_q[u_idx] - 2'd1);
            end
         end else if (i_upd_taken) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= WT;
         end
      end
   end

   // On a taken hit the tag is rewritten with its own value, so no hit check is needed here.
   always_ff @(posedge i_clk) begin
      if (i_upd_en && i_upd_taken) begin
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= i_upd_target;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC register, next-PC selection and BTB-based prediction.
// Outputs describe the current pc_q and are captured by the IF/ID register at the edge.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = BTB_ENTRIES_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_upd_en,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_pred_taken
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        pred_taken;
   logic [31:0] pred_target;

   btb_bht #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_lkp_pc      (pc_q),
      .o_pred_taken  (pred_taken),
      .o_pred_target (pred_target),
      .i_upd_en      (i_upd_en),
      .i_upd_pc      (i_upd_pc),
      .i_upd_taken   (i_upd_taken),
      .i_upd_target  (i_upd_target)
   );

   // Redirect beats stall: the controller flushes IF/ID in the same cycle.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (i_redirect) begin
         pc_d = i_redirect_pc & ~32'd3;
      end else if (i_stall) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target & ~32'd3;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign o_imem_addr  = pc_q;
   assign o_pc         = pc_q;
   assign o_instr      = i_imem_rdata;
   assign o_pred_taken = pred_taken;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, stall/redirect, BTB allocation, counters,
// aliasing, same-cycle update/lookup and PC wrap, against hand-computed values.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        pred_taken;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instruction memory stand-in: each word is recognisable from its address.
   assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

   if_fetch_stage dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_upd_en      (upd_en),
      .i_upd_pc      (upd_pc),
      .i_upd_taken   (upd_taken),
      .i_upd_target  (upd_target),
      .o_imem_addr   (imem_addr),
      .i_imem_rdata  (imem_rdata),
      .o_pc          (pc),
      .o_instr       (instr),
      .o_pred_taken  (pred_taken)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      step();
      redirect    = 1'b0;
   endtask

   task automatic upd(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
      upd_en     = 1'b1;
      upd_pc     = upc;
      upd_taken  = taken;
      upd_target = tgt;
      step();
      upd_en     = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
      checks++; if (instr !== 32'hDEAD_0000) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'hDEAD_0000); end
      step();
      reset = 1'b0;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL release_pc0 got=%h exp=%h", pc, 32'h0); end
      step();
      checks++; if (pc !== 32'h4) begin failures++; $display("FAIL release_pc1 got=%h exp=%h", pc, 32'h4); end
      step();
      checks++; if (pc !== 32'h8) begin failures++; $display("FAIL release_pc2 got=%h exp=%h", pc, 32'h8); end
      for (int i = 0; i < 14; i++) step();
      checks++; if (pc !== 32'h40) begin failures++; $display("FAIL run_to_40 got=%h exp=%h", pc, 32'h40); end
      reset = 1'b1;
      #1;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midrun_reset_pc got=%h exp=%h", pc, 32'h0); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL midrun_reset_pred got=%b exp=0", pred_taken); end
      step();
      reset = 1'b0;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rerelease_pc0 got=%h exp=%h", pc, 32'h0); end
      step();
      checks++; if (pc !== 32'h4) begin failures++; $display("FAIL rerelease_pc1 got=%h exp=%h", pc, 32'h4); end
      step();
      checks++; if (pc !== 32'h8) begin failures++; $display("FAIL rerelease_pc2 got=%h exp=%h", pc, 32'h8); end
   endtask

   task automatic test_stall_redirect();
      goto_pc(32'h10);
      checks++; if (pc !== 32'h10) begin failures++; $display("FAIL goto_10 got=%h exp=%h", pc, 32'h10); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, pc, 32'h10); end
      end
      checks++; if (instr !== 32'hDEAD_0010) begin failures++; $display("FAIL stall_instr got=%h exp=%h", instr, 32'hDEAD_0010); end
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      stall    = 1'b0;
      checks++; if (pc !== 32'h200) begin failures++; $display("FAIL redirect_over_stall got=%h exp=%h", pc, 32'h200); end
      step();
      checks++; if (pc !== 32'h204) begin failures++; $display("FAIL after_redirect got=%h exp=%h", pc, 32'h204); end
   endtask

   task automatic test_btb_alloc();
      upd(32'h20, 1'b1, 32'h80);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_pred got=%b exp=1", pred_taken); end
      step();
      checks++; if (pc !== 32'h80) begin failures++; $display("FAIL alloc_target got=%h exp=%h", pc, 32'h80); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alloc_other_idx got=%b exp=0", pred_taken); end
   endtask

   task automatic test_counter_saturation();
      for (int i = 0; i < 3; i++) upd(32'h20, 1'b1, 32'h80);
      upd(32'h20, 1'b0, 32'h0);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL st_minus1_pred got=%b exp=1", pred_taken); end
      step();
      checks++; if (pc !== 32'h80) begin failures++; $display("FAIL st_minus1_next got=%h exp=%h", pc, 32'h80); end
      upd(32'h20, 1'b0, 32'h0);
      upd(32'h20, 1'b0, 32'h0);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL snt_pred got=%b exp=0", pred_taken); end
      step();
      checks++; if (pc !== 32'h24) begin failures++; $display("FAIL snt_next got=%h exp=%h", pc, 32'h24); end
      // SNT -> WNT -> WT with a new target on each taken hit.
      upd(32'h20, 1'b1, 32'h90);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL wnt_pred got=%b exp=0", pred_taken); end
      upd(32'h20, 1'b1, 32'h90);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL wt_again_pred got=%b exp=1", pred_taken); end
      step();
      checks++; if (pc !== 32'h90) begin failures++; $display("FAIL hit_new_target got=%h exp=%h", pc, 32'h90); end
   endtask

   task automatic test_aliasing();
      upd(32'h60, 1'b1, 32'h100);
      goto_pc(32'h20);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_old_pred got=%b exp=0", pred_taken); end
      step();
      checks++; if (pc !== 32'h24) begin failures++; $display("FAIL alias_old_next got=%h exp=%h", pc, 32'h24); end
      goto_pc(32'h60);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_new_pred got=%b exp=1", pred_taken); end
      step();
      checks++; if (pc !== 32'h100) begin failures++; $display("FAIL alias_new_next got=%h exp=%h", pc, 32'h100); end
   endtask

   task automatic test_same_cycle();
      goto_pc(32'h30);
      upd_en     = 1'b1;
      upd_pc     = 32'h30;
      upd_taken  = 1'b1;
      upd_target = 32'h200;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_cycle_pred got=%b exp=0", pred_taken); end
      step();
      upd_en = 1'b0;
      checks++; if (pc !== 32'h34) begin failures++; $display("FAIL same_cycle_next got=%h exp=%h", pc, 32'h34); end
      goto_pc(32'h30);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL revisit_pred got=%b exp=1", pred_taken); end
      step();
      checks++; if (pc !== 32'h200) begin failures++; $display("FAIL revisit_next got=%h exp=%h", pc, 32'h200); end
   endtask

   task automatic test_not_taken_miss();
      upd(32'h44, 1'b0, 32'h300);
      goto_pc(32'h44);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nt_miss_pred got=%b exp=0", pred_taken); end
      step();
      checks++; if (pc !== 32'h48) begin failures++; $display("FAIL nt_miss_next got=%h exp=%h", pc, 32'h48); end
      // Same index as 0x30 with a different tag: must not disturb that entry.
      upd(32'h70, 1'b0, 32'h400);
      goto_pc(32'h30);
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL nt_miss_keep got=%b exp=1", pred_taken); end
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL wrap_pred got=%b exp=0", pred_taken); end
      checks++; if (instr !== 32'h2152_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=%h", instr, 32'h2152_FFFC); end
      step();
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=%h", pc, 32'h0); end
   endtask

   task automatic test_reset_clears_btb();
      reset = 1'b1;
      #1;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset2_pc got=%h exp=%h", pc, 32'h0); end
      step();
      reset = 1'b0;
      goto_pc(32'h30);
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset2_pred got=%b exp=0", pred_taken); end
      step();
      checks++; if (pc !== 32'h34) begin failures++; $display("FAIL reset2_next got=%h exp=%h", pc, 32'h34); end
   endtask

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      upd_en      = 1'b0;
      upd_pc      = 32'h0;
      upd_taken   = 1'b0;
      upd_target  = 32'h0;
      test_reset();
      test_stall_redirect();
      test_btb_alloc();
      test_counter_saturation();
      test_aliasing();
      test_same_cycle();
      test_not_taken_miss();
      test_wrap();
      test_reset_clears_btb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
